// File: rtl/fetch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_redirect_ctrl
//
// Sequences front-end redirects between the backend and the fetch front.
// Exception/ertn requests and EX-stage mispredict requests are arbitrated.
// Any outstanding icache access is drained first. Then exactly one clean
// redirect is issued: new_pc, plus a pc/instbuffer flush.
//
// Handshake: exc_req and br_req are single-cycle pulses with no ready/backpressure.
// A pulse is either latched on the cycle it is seen or dropped. A dropped pulse is
// a br_req while WAIT holds a target. The only output-side handshake is
// redirect_valid. It is a one-cycle strobe that the pc unit must consume in that cycle.
//
// Ports:
//   cpu_clk        clock, all state on the rising edge
//   cpu_rst        asynchronous active-low reset
//   exc_req/exc_pc exception/ertn redirect request and target (wins arbitration)
//   br_req/br_pc   EX mispredict redirect request and correct target
//   icache_busy    icache has an outstanding fetch/refill
//   redirect_valid one-cycle pulse: new_pc valid, pc must load it
//   new_pc         redirect target; holds the last issued target otherwise
//   fb_flush       [0] pc flush, [1] instbuffer flush
//   fetch_pause    holds the pc while a redirect is pending
//   busy           controller is not idle
//   redirect_cnt   saturating count of issued redirects
//   timeout_flag   sticky: a WAIT was ended by the WAIT_MAX limit
//   state_dbg      current FSM state (IDLE=0, WAIT=1, ISSUE=2)
//   kind_dbg       latched request kind (0=branch, 1=exception)
// -----------------------------------------------------------------------------
module fetch_redirect_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 64,
  parameter int CNT_W    = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_pc,
  input  logic              br_req,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic              icache_busy,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] new_pc,
  output logic [1:0]        fb_flush,
  output logic              fetch_pause,
  output logic              busy,
  output logic [CNT_W-1:0]  redirect_cnt,
  output logic              timeout_flag,
  output logic [1:0]        state_dbg,
  output logic              kind_dbg
);

  localparam int WCNT_W = $clog2(WAIT_MAX) + 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  typedef enum logic {
    K_BR  = 1'b0,
    K_EXC = 1'b1
  } kind_t;

  state_t             state, nxt_state;
  kind_t              kind, nxt_kind;
  logic [ADDR_W-1:0]  target, nxt_target;
  logic [WCNT_W-1:0]  wait_cnt, nxt_wait_cnt;
  logic               set_timeout;

  logic               req_any;
  logic [ADDR_W-1:0]  req_pc;
  kind_t              req_kind;

  // Exception/ertn always wins over a same-cycle mispredict.
  assign req_any  = exc_req | br_req;
  assign req_pc   = exc_req ? exc_pc : br_pc;
  assign req_kind = exc_req ? K_EXC : K_BR;

  always_comb begin
    nxt_state    = state;
    nxt_kind     = kind;
    nxt_target   = target;
    nxt_wait_cnt = wait_cnt;
    set_timeout  = 1'b0;
    case (state)
      S_IDLE, S_ISSUE: begin
        // ISSUE accepts a new request like IDLE, so back-to-back redirects need no idle gap.
        if (req_any) begin
          nxt_target   = req_pc;
          nxt_kind     = req_kind;
          nxt_wait_cnt = '0;
          nxt_state    = icache_busy ? S_WAIT : S_ISSUE;
        end else begin
          nxt_state = S_IDLE;
        end
      end
      S_WAIT: begin
        // A late exception supersedes the pending target. A late mispredict
        // belongs to a now-squashed path and is dropped.
        if (exc_req) begin
          nxt_target = exc_pc;
          nxt_kind   = K_EXC;
        end
        if (!icache_busy) begin
          nxt_state = S_ISSUE;
        end else if (wait_cnt == WAIT_LAST) begin
          nxt_state   = S_ISSUE;
          set_timeout = 1'b1;
        end else begin
          nxt_wait_cnt = wait_cnt + WCNT_W'(1);
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state          <= S_IDLE;
      kind           <= K_BR;
      target         <= '0;
      wait_cnt       <= '0;
      redirect_valid <= 1'b0;
      new_pc         <= '0;
      fb_flush       <= 2'b00;
      fetch_pause    <= 1'b0;
      busy           <= 1'b0;
      redirect_cnt   <= '0;
      timeout_flag   <= 1'b0;
    end else begin
      state          <= nxt_state;
      kind           <= nxt_kind;
      target         <= nxt_target;
      wait_cnt       <= nxt_wait_cnt;
      redirect_valid <= (nxt_state == S_ISSUE);
      fetch_pause    <= (nxt_state == S_WAIT);
      busy           <= (nxt_state != S_IDLE);
      case (nxt_state)
        S_ISSUE: fb_flush <= 2'b11;
        S_WAIT:  fb_flush <= 2'b10;   // discard stale icache returns
        default: fb_flush <= 2'b00;
      endcase
      if (nxt_state == S_ISSUE) begin
        new_pc <= nxt_target;
        if (redirect_cnt != '1) begin
          redirect_cnt <= redirect_cnt + CNT_W'(1);
        end
      end
      if (set_timeout) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  assign state_dbg = state;
  assign kind_dbg  = kind;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;

  localparam int ADDR_W = 32;

  // ---------------- clock / reset ----------------
  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // ---------------- main DUT signals ----------------
  logic              exc_req, br_req, icache_busy;
  logic [ADDR_W-1:0] exc_pc, br_pc;
  logic              redirect_valid, fetch_pause, busy, timeout_flag, kind_dbg;
  logic [ADDR_W-1:0] new_pc;
  logic [1:0]        fb_flush, state_dbg;
  logic [15:0]       redirect_cnt;

  // ---------------- small-counter DUT signals ----------------
  logic              s_exc_req, s_br_req, s_icache_busy;
  logic [ADDR_W-1:0] s_exc_pc, s_br_pc;
  logic              s_redirect_valid, s_fetch_pause, s_busy, s_timeout_flag, s_kind_dbg;
  logic [ADDR_W-1:0] s_new_pc;
  logic [1:0]        s_fb_flush, s_state_dbg;
  logic [3:0]        s_redirect_cnt;

  fetch_redirect_ctrl #(.ADDR_W(ADDR_W), .WAIT_MAX(64), .CNT_W(16)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .exc_req(exc_req), .exc_pc(exc_pc), .br_req(br_req), .br_pc(br_pc),
    .icache_busy(icache_busy),
    .redirect_valid(redirect_valid), .new_pc(new_pc), .fb_flush(fb_flush),
    .fetch_pause(fetch_pause), .busy(busy), .redirect_cnt(redirect_cnt),
    .timeout_flag(timeout_flag), .state_dbg(state_dbg), .kind_dbg(kind_dbg)
  );

  fetch_redirect_ctrl #(.ADDR_W(ADDR_W), .WAIT_MAX(4), .CNT_W(4)) u_sat (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .exc_req(s_exc_req), .exc_pc(s_exc_pc), .br_req(s_br_req), .br_pc(s_br_pc),
    .icache_busy(s_icache_busy),
    .redirect_valid(s_redirect_valid), .new_pc(s_new_pc), .fb_flush(s_fb_flush),
    .fetch_pause(s_fetch_pause), .busy(s_busy), .redirect_cnt(s_redirect_cnt),
    .timeout_flag(s_timeout_flag), .state_dbg(s_state_dbg), .kind_dbg(s_kind_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [ADDR_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every redirect pulse must match the oldest expected target.
  always @(negedge cpu_clk) begin
    if (cpu_rst && redirect_valid) begin
      pulses++;
      if (exp_q.size() == 0) check("unexpected_redirect", new_pc, 64'hDEAD);
      else                   check("redirect_pc", new_pc, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int waits, n, p0;
    exc_req = 0; br_req = 0; icache_busy = 0; exc_pc = '0; br_pc = '0;
    s_exc_req = 0; s_br_req = 0; s_icache_busy = 0; s_exc_pc = '0; s_br_pc = '0;

    // Reset state
    repeat (3) @(posedge cpu_clk);
    #1;
    check("rst_valid", redirect_valid, 0);
    check("rst_new_pc", new_pc, 0);
    check("rst_flush", fb_flush, 0);
    check("rst_pause", fetch_pause, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", redirect_cnt, 0);
    check("rst_timeout", timeout_flag, 0);
    check("rst_state", state_dbg, 0);
    cpu_rst = 1;
    step();

    // 1: simple branch redirect, icache idle
    exp_q.push_back(32'h1C00_0040);
    br_req = 1; br_pc = 32'h1C00_0040;
    check("t1_req_cycle_valid", redirect_valid, 0);
    step();
    br_req = 0;
    check("t1_valid", redirect_valid, 1);
    check("t1_new_pc", new_pc, 32'h1C00_0040);
    check("t1_flush", fb_flush, 2'b11);
    check("t1_pause", fetch_pause, 0);
    check("t1_cnt", redirect_cnt, 1);
    step();
    check("t1_after_valid", redirect_valid, 0);
    check("t1_hold_pc", new_pc, 32'h1C00_0040);
    check("t1_after_busy", busy, 0);
    check("t1_after_flush", fb_flush, 0);

    // 2: exception beats same-cycle branch
    exp_q.push_back(32'h1C00_8000);
    exc_req = 1; exc_pc = 32'h1C00_8000; br_req = 1; br_pc = 32'h0000_2000;
    step();
    exc_req = 0; br_req = 0;
    check("t2_new_pc", new_pc, 32'h1C00_8000);
    check("t2_kind", kind_dbg, 1);
    check("t2_cnt", redirect_cnt, 2);
    step();
    check("t2_single", redirect_valid, 0);

    // 3: icache busy for 5 cycles -> 5 WAIT cycles then ISSUE
    exp_q.push_back(32'h1C00_0100);
    br_req = 1; br_pc = 32'h1C00_0100; icache_busy = 1;
    step();
    br_req = 0;
    waits = 0;
    for (int i = 0; i < 5; i++) begin
      if (fetch_pause && fb_flush == 2'b10 && !redirect_valid) waits++;
      if (i == 4) icache_busy = 0;
      step();
    end
    check("t3_wait_cycles", waits, 5);
    check("t3_valid", redirect_valid, 1);
    check("t3_new_pc", new_pc, 32'h1C00_0100);
    check("t3_flush", fb_flush, 2'b11);
    check("t3_pause", fetch_pause, 0);
    step();

    // 4: exception overwrites in WAIT, later branch ignored
    exp_q.push_back(32'h1C00_8000);
    br_req = 1; br_pc = 32'h0000_0100; icache_busy = 1;
    step();
    br_req = 0;
    step();
    exc_req = 1; exc_pc = 32'h1C00_8000;
    step();
    exc_req = 0;
    check("t4_still_wait", fetch_pause, 1);
    br_req = 1; br_pc = 32'h0000_0300;
    step();
    br_req = 0; icache_busy = 0;
    step();
    check("t4_valid", redirect_valid, 1);
    check("t4_new_pc", new_pc, 32'h1C00_8000);
    step();
    check("t4_no_extra", redirect_valid, 0);
    check("t4_idle", busy, 0);

    // 5: icache stuck busy -> timeout after 64 WAIT cycles
    exp_q.push_back(32'h1C00_0200);
    br_req = 1; br_pc = 32'h1C00_0200; icache_busy = 1;
    step();
    br_req = 0;
    check("t5_timeout_before", timeout_flag, 0);
    waits = 0; n = 0;
    while (!redirect_valid && n < 200) begin
      if (fetch_pause) waits++;
      n++;
      step();
    end
    check("t5_reached_issue", redirect_valid, 1);
    check("t5_wait_cycles", waits, 64);
    check("t5_timeout", timeout_flag, 1);
    icache_busy = 0;
    step();
    check("t5_timeout_sticky", timeout_flag, 1);
    check("t5_cnt", redirect_cnt, 5);
    check("t5_idle", busy, 0);

    // 6: reset mid-WAIT
    br_req = 1; br_pc = 32'h1C00_0300; icache_busy = 1;
    step();
    br_req = 0;
    step();
    check("t6_in_wait", fetch_pause, 1);
    #2;
    cpu_rst = 0;
    exp_q.delete();
    #1;
    check("t6_pause", fetch_pause, 0);
    check("t6_flush", fb_flush, 0);
    check("t6_busy", busy, 0);
    check("t6_cnt", redirect_cnt, 0);
    check("t6_timeout", timeout_flag, 0);
    check("t6_new_pc", new_pc, 0);
    check("t6_state", state_dbg, 0);
    @(posedge cpu_clk);
    #1;
    cpu_rst = 1; icache_busy = 0;
    p0 = pulses;
    repeat (5) step();
    check("t6_no_redirect", pulses - p0, 0);
    check("t6_idle", busy, 0);

    // 7: back-to-back redirects through ISSUE
    exp_q.push_back(32'h1C00_0400);
    exp_q.push_back(32'h1C00_0500);
    br_req = 1; br_pc = 32'h1C00_0400;
    step();
    check("t7_first_pc", new_pc, 32'h1C00_0400);
    br_pc = 32'h1C00_0500;
    step();
    br_req = 0;
    check("t7_second_valid", redirect_valid, 1);
    check("t7_second_pc", new_pc, 32'h1C00_0500);
    check("t7_cnt", redirect_cnt, 2);
    step();
    check("t7_done", redirect_valid, 0);

    // Counter saturation on the 4-bit instance
    s_br_req = 1; s_br_pc = 32'h0000_0010;
    repeat (20) step();
    check("sat_valid", s_redirect_valid, 1);
    check("sat_cnt", s_redirect_cnt, 4'hF);
    s_br_req = 0;
    step();
    check("sat_cnt_hold", s_redirect_cnt, 4'hF);
    check("sat_idle_valid", s_redirect_valid, 0);

    // Final report
    check("redirect_pulses", pulses, 7);
    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
